// File: rtl/fourbit_shift_reg_blockassig.sv
// fourbit_shift_reg_blockassig
// DEPTH-stage serial-in shift register. It has a parallel view of all stages,
// a saturating fill counter and a "primed" flag.
// clear is synchronous and active-low. It wins over shifting on any edge.
// The optional macro FOURBIT_SHIFT_REG_ONES_COUNT_EN adds ones_cnt.
// ones_cnt is a registered population count of q, updated incrementally.
module fourbit_shift_reg_blockassig #(
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       clear,
   input  logic                       s_in,
   output logic                       s_out,
   output logic [DEPTH-1:0]           q,
   output logic                       primed,
   output logic [$clog2(DEPTH+1)-1:0] fill_cnt
`ifdef FOURBIT_SHIFT_REG_ONES_COUNT_EN
   ,
   output logic [$clog2(DEPTH+1)-1:0] ones_cnt
`endif
);

   localparam int CW = $clog2(DEPTH+1);
   localparam logic [CW-1:0] FULL = CW'(DEPTH);
   localparam logic [CW-1:0] ONE  = CW'(1);

   logic [DEPTH-1:0] stage_reg;
   wire  [DEPTH-1:0] stage_next;
   logic [CW-1:0]    fill_reg;
   logic [CW-1:0]    fill_next;
   logic             primed_reg;

   // Each stage reads the previous stage's registered value.
   // Stage 0 reads s_in. This keeps one flop per stage with no fall-through.
   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
         if (gi == 0) begin : g_head
            assign stage_next[gi] = s_in;
         end else begin : g_body
            assign stage_next[gi] = stage_reg[gi-1];
         end
      end
   endgenerate

   // Saturating count of bits shifted in since the last reset.
   always_comb begin
      fill_next = fill_reg;
      if (fill_reg != FULL)
         fill_next = fill_reg + ONE;
   end

   // Shift stages, fill counter and primed flag together. Reset has priority.
   always_ff @(posedge clk) begin
      if (!clear) begin
         stage_reg  <= '0;
         fill_reg   <= '0;
         primed_reg <= 1'b0;
      end else begin
         stage_reg  <= stage_next;
         fill_reg   <= fill_next;
         primed_reg <= (fill_next == FULL);
      end
   end

   assign q        = stage_reg;
   assign s_out    = stage_reg[DEPTH-1];
   assign fill_cnt = fill_reg;
   assign primed   = primed_reg;

`ifdef FOURBIT_SHIFT_REG_ONES_COUNT_EN
   logic [CW-1:0] ones_reg;

   // Running popcount of q.
   // A 1 entering at q[0] adds one, and a 1 leaving from s_out subtracts one.
   // When both happen on the same edge they cancel out.
   always_ff @(posedge clk) begin
      if (!clear) begin
         ones_reg <= '0;
      end else begin
         case ({s_in, stage_reg[DEPTH-1]})
            2'b10:   ones_reg <= ones_reg + ONE;
            2'b01:   ones_reg <= ones_reg - ONE;
            default: ones_reg <= ones_reg;
         endcase
      end
   end

   assign ones_cnt = ones_reg;
`endif

endmodule

// File: tb/tb_fourbit_shift_reg_blockassig.sv
// Testbench for fourbit_shift_reg_blockassig.
// Runs a DEPTH=4 instance against a history-queue reference model.
// Runs a second DEPTH=8 instance to measure latency.
// Define FOURBIT_SHIFT_REG_ONES_COUNT_EN to also check ones_cnt.
module tb_fourbit_shift_reg_blockassig;

   logic       clk = 1'b0;
   logic       clear = 1'b0;
   logic       s_in = 1'b0;
   logic       s_in8 = 1'b0;
   logic       s_out, primed, s_out8, primed8;
   logic [3:0] q;
   logic [7:0] q8;
   logic [2:0] fill_cnt;
   logic [3:0] fill_cnt8;
`ifdef FOURBIT_SHIFT_REG_ONES_COUNT_EN
   logic [2:0] ones_cnt;
   logic [3:0] ones_cnt8;
`endif

   int total = 0;
   int bad = 0;

   // Reference model state: bits shifted in since reset, newest first.
   bit hist[$];
   int n_shift = 0;

   always #5 clk = ~clk;

   fourbit_shift_reg_blockassig #(.DEPTH(4)) dut4 (
      .clk(clk), .clear(clear), .s_in(s_in), .s_out(s_out), .q(q),
      .primed(primed), .fill_cnt(fill_cnt)
`ifdef FOURBIT_SHIFT_REG_ONES_COUNT_EN
      , .ones_cnt(ones_cnt)
`endif
   );

   fourbit_shift_reg_blockassig #(.DEPTH(8)) dut8 (
      .clk(clk), .clear(clear), .s_in(s_in8), .s_out(s_out8), .q(q8),
      .primed(primed8), .fill_cnt(fill_cnt8)
`ifdef FOURBIT_SHIFT_REG_ONES_COUNT_EN
      , .ones_cnt(ones_cnt8)
`endif
   );

   function automatic logic [3:0] exp_q();
      logic [3:0] v = '0;
      for (int i = 0; i < 4; i++)
         if (i < hist.size()) v[i] = hist[i];
      return v;
   endfunction

   function automatic int exp_fill();
      return (n_shift < 4) ? n_shift : 4;
   endfunction

   function automatic int exp_ones();
      logic [3:0] v = exp_q();
      return $countones(v);
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock edge: update the model with the sampled inputs, then settle.
   task automatic tick();
      @(posedge clk);
      if (!clear) begin
         hist.delete();
         n_shift = 0;
      end else begin
         hist.push_front(s_in);
         if (hist.size() > 4) void'(hist.pop_back());
         n_shift++;
      end
      #1;
   endtask

   task automatic check_model(input string tag);
      logic [3:0] eq = exp_q();
      check({tag, "_q"}, 32'(q), 32'(eq));
      check({tag, "_s_out"}, 32'(s_out), 32'(eq[3]));
      check({tag, "_fill"}, 32'(fill_cnt), 32'(exp_fill()));
      check({tag, "_primed"}, 32'(primed), 32'(exp_fill() == 4));
`ifdef FOURBIT_SHIFT_REG_ONES_COUNT_EN
      check({tag, "_ones"}, 32'(ones_cnt), 32'(exp_ones()));
`endif
   endtask

   initial begin
      bit seq_in [9]   = '{1,0,0,1,0,1,0,0,1};
      bit seq_out [9]  = '{0,0,0,1,0,0,1,0,1};
      int edges;

      // Reset for two edges.
      clear = 1'b0;
      tick();
      tick();
      check("rst_q", 32'(q), 32'h0);
      check("rst_s_out", 32'(s_out), 32'h0);
      check("rst_fill", 32'(fill_cnt), 32'h0);
      check("rst_primed", 32'(primed), 32'h0);
      check("rst_q8", 32'(q8), 32'h0);

      // Directed serial stream: check the latency of s_out and the fill count.
      clear = 1'b1;
      for (int i = 0; i < 9; i++) begin
         s_in = seq_in[i];
         tick();
         $display("seq edge %0d s_in=%0d s_out=%0d fill=%0d", i + 1, seq_in[i], s_out, fill_cnt);
         check($sformatf("seq_s_out_%0d", i + 1), 32'(s_out), 32'(seq_out[i]));
         check_model($sformatf("seq_%0d", i + 1));
         if (i == 2) begin
            check("fill_after3", 32'(fill_cnt), 32'd3);
            check("primed_after3", 32'(primed), 32'd0);
         end
         if (i == 3) begin
            check("fill_after4", 32'(fill_cnt), 32'd4);
            check("primed_after4", 32'(primed), 32'd1);
         end
      end
      s_in = 1'b0;
      tick();
      check("fill_after10", 32'(fill_cnt), 32'd4);

      // Reset mid-stream discards everything and restarts counting.
      s_in = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      check("ones_q_before_clear", 32'(q), 32'hF);
      clear = 1'b0;
      tick();
      check("midclr_q", 32'(q), 32'h0);
      check("midclr_fill", 32'(fill_cnt), 32'h0);
      clear = 1'b1;
      s_in = 1'b1;
      tick();
      check("post_clr_q", 32'(q), 32'h1);
      check("post_clr_fill", 32'(fill_cnt), 32'h1);

`ifdef FOURBIT_SHIFT_REG_ONES_COUNT_EN
      // Popcount: the last step has a 1 entering and a 1 leaving on the same edge.
      begin
         bit   oseq [5] = '{1,1,0,1,1};
         int   oexp [5] = '{1,2,2,3,3};
         clear = 1'b0;
         tick();
         clear = 1'b1;
         for (int i = 0; i < 5; i++) begin
            s_in = oseq[i];
            tick();
            $display("ones edge %0d s_in=%0d ones_cnt=%0d", i + 1, oseq[i], ones_cnt);
            check($sformatf("ones_cnt_%0d", i + 1), 32'(ones_cnt), 32'(oexp[i]));
         end
      end
`endif

      // DEPTH=8 latency: a single 1 must reach s_out on the 8th edge, counting the one that sampled it.
      clear = 1'b0;
      s_in = 1'b0;
      tick();
      clear = 1'b1;
      s_in8 = 1'b1;
      tick();
      edges = 1;
      s_in8 = 1'b0;
      while (s_out8 !== 1'b1 && edges < 20) begin
         tick();
         edges++;
      end
      $display("depth8 s_out rose after %0d edges", edges);
      check("depth8_latency", 32'(edges), 32'd8);
      check("depth8_fill", 32'(fill_cnt8), 32'd8);
      check("depth8_primed", 32'(primed8), 32'd1);

      // Random stream with occasional resets, checked against the model.
      for (int i = 0; i < 200; i++) begin
         clear = ($urandom_range(15) != 0);
         s_in = 1'($urandom_range(1));
         s_in8 = 1'($urandom_range(1));
         tick();
         $display("rand %0d clear=%0d s_in=%0d q=%b fill=%0d", i, clear, s_in, q, fill_cnt);
         check_model($sformatf("rand_%0d", i));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Watchdog in case the bench ever stops advancing.
   initial begin
      #200000;
      $display("FAIL watchdog timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
